// File: rtl/sprite_pkg.sv
// Shared timing constants and types for the sprite display path.
package sprite_pkg;

  localparam int H_ACTIVE     = 640;
  localparam int H_SYNC_START = 656;
  localparam int H_SYNC_END   = 751;
  localparam int H_TOTAL      = 800;
  localparam int V_ACTIVE     = 480;
  localparam int V_SYNC_START = 490;
  localparam int V_SYNC_END   = 491;
  localparam int V_TOTAL      = 525;

  localparam int TABLE_DEPTH  = 32;
  localparam int ID_W         = $clog2(TABLE_DEPTH);
  localparam int SCAN_START   = H_ACTIVE;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic       vis;
  } spr_entry_t;

  typedef struct packed {
    logic [9:0]      x;
    logic [ID_W-1:0] id;
    logic            valid;
  } spr_slot_t;

  typedef enum logic [1:0] {
    SCAN_IDLE = 2'd0,
    SCAN_RUN  = 2'd1,
    SCAN_DONE = 2'd2
  } scan_state_e;

  // Line whose slot list is being built while line v is on screen.
  function automatic logic [9:0] target_line(input logic [9:0] v);
    return (v == 10'(V_TOTAL - 1)) ? 10'd0 : v + 10'd1;
  endfunction

endpackage

// File: rtl/vga_sync_gen.sv
// 640x480 VGA raster counters with combinational sync/active decode.
module vga_sync_gen
  import sprite_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       active
);

  logic [9:0] h_q, h_d;
  logic [9:0] v_q, v_d;

  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_q == 10'(H_TOTAL - 1)) begin
      h_d = '0;
      v_d = (v_q == 10'(V_TOTAL - 1)) ? 10'd0 : v_q + 10'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_cnt   = h_q;
  assign v_cnt   = v_q;
  assign hsync_n = !((h_q >= 10'(H_SYNC_START)) && (h_q <= 10'(H_SYNC_END)));
  assign vsync_n = !((v_q >= 10'(V_SYNC_START)) && (v_q <= 10'(V_SYNC_END)));
  assign active  = (h_q < 10'(H_ACTIVE)) && (v_q < 10'(V_ACTIVE));

endmodule

// File: rtl/sprite_engine.sv
// Sprite table, per-line slot selection and registered pixel stream.
// Optional sticky overflow flag enabled by defining SPRITE_OVF_EN.
module sprite_engine
  import sprite_pkg::*;
#(
  parameter int SLOTS = 4,
  parameter int SPR_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] spsel,
  input  logic [9:0] spx,
  input  logic [8:0] spy,
  input  logic       sppos,
  input  logic       spattr,
  input  logic       spvis,
  input  logic [1:0] bg,
  output logic       hsync,
  output logic       vsync,
  output logic       active,
  output logic       pix_hit,
  output logic [4:0] pix_id,
  output logic [1:0] pix_bg,
  output logic       spr_ovf
);

  localparam int CNT_W = $clog2(SLOTS + 1);

  logic [9:0] h_cnt, v_cnt;
  logic       hsync_n, vsync_n, raster_active;

  vga_sync_gen u_sync (
    .clk     (clk),
    .rst     (rst),
    .h_cnt   (h_cnt),
    .v_cnt   (v_cnt),
    .hsync_n (hsync_n),
    .vsync_n (vsync_n),
    .active  (raster_active)
  );

  spr_entry_t table_q [TABLE_DEPTH];
  spr_entry_t table_d [TABLE_DEPTH];

  always_comb begin
    for (int i = 0; i < TABLE_DEPTH; i++) table_d[i] = table_q[i];
    if (sppos) begin
      table_d[spsel].x = spx;
      table_d[spsel].y = spy;
    end
    if (spattr) table_d[spsel].vis = spvis;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TABLE_DEPTH; i++) table_q[i] <= '0;
    end else begin
      for (int i = 0; i < TABLE_DEPTH; i++) table_q[i] <= table_d[i];
    end
  end

  scan_state_e     state_q, state_d;
  logic [ID_W-1:0] k_q, k_d;
  logic            scan_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SCAN_IDLE;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SCAN_IDLE: if (h_cnt == 10'(SCAN_START)) state_d = SCAN_RUN;
      SCAN_RUN:  if (k_q == ID_W'(TABLE_DEPTH - 1)) state_d = SCAN_DONE;
      SCAN_DONE: if (h_cnt == 10'd0) state_d = SCAN_IDLE;
      default:   state_d = SCAN_IDLE;
    endcase
  end

  always_comb begin
    scan_en = (state_q == SCAN_RUN);
    k_d     = scan_en ? k_q + ID_W'(1) : '0;
  end

  // Table read sees the pre-write value, so a same-cycle write is not observed.
  spr_entry_t cur_entry;
  logic [9:0] tgt_line;
  logic [8:0] dy;
  logic       qualify;

  always_comb begin
    cur_entry = table_q[k_q];
    tgt_line  = target_line(v_cnt);
    dy        = tgt_line[8:0] - cur_entry.y;
    qualify   = scan_en && cur_entry.vis && (tgt_line < 10'(V_ACTIVE)) && (dy < 9'(SPR_W));
  end

  spr_slot_t        back_q  [SLOTS];
  spr_slot_t        back_d  [SLOTS];
  spr_slot_t        front_q [SLOTS];
  spr_slot_t        front_d [SLOTS];
  logic [CNT_W-1:0] back_cnt_q, back_cnt_d;
  logic             line_end;
  logic             drop;

  always_comb begin
    line_end   = (h_cnt == 10'(H_TOTAL - 1));
    back_cnt_d = back_cnt_q;
    drop       = 1'b0;
    for (int i = 0; i < SLOTS; i++) begin
      back_d[i]  = back_q[i];
      front_d[i] = front_q[i];
    end
    if (line_end) begin
      for (int i = 0; i < SLOTS; i++) begin
        front_d[i] = back_q[i];
        back_d[i]  = '0;
      end
      back_cnt_d = '0;
    end else if (qualify) begin
      if (back_cnt_q < CNT_W'(SLOTS)) begin
        for (int i = 0; i < SLOTS; i++) begin
          if (CNT_W'(i) == back_cnt_q) back_d[i] = '{x: cur_entry.x, id: k_q, valid: 1'b1};
        end
        back_cnt_d = back_cnt_q + CNT_W'(1);
      end else begin
        drop = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SLOTS; i++) begin
        back_q[i]  <= '0;
        front_q[i] <= '0;
      end
      back_cnt_q <= '0;
    end else begin
      for (int i = 0; i < SLOTS; i++) begin
        back_q[i]  <= back_d[i];
        front_q[i] <= front_d[i];
      end
      back_cnt_q <= back_cnt_d;
    end
  end

  // Walk slots high to low so the lowest slot (lowest sprite id) wins.
  logic            hit_any;
  logic [ID_W-1:0] hit_id;
  logic [9:0]      dx;

  always_comb begin
    hit_any = 1'b0;
    hit_id  = '0;
    dx      = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      dx = h_cnt - front_q[i].x;
      if (front_q[i].valid && (dx < 10'(SPR_W))) begin
        hit_any = 1'b1;
        hit_id  = front_q[i].id;
      end
    end
  end

  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       active_q, active_d;
  logic       hit_q, hit_d;
  logic [4:0] id_q, id_d;
  logic [1:0] bg_q, bg_d;

  always_comb begin
    hsync_d  = hsync_n;
    vsync_d  = vsync_n;
    active_d = raster_active;
    hit_d    = hit_any && raster_active;
    id_d     = (hit_any && raster_active) ? 5'(hit_id) : 5'd0;
    bg_d     = bg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hsync_q  <= 1'b1;
      vsync_q  <= 1'b1;
      active_q <= 1'b0;
      hit_q    <= 1'b0;
      id_q     <= '0;
      bg_q     <= '0;
    end else begin
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      active_q <= active_d;
      hit_q    <= hit_d;
      id_q     <= id_d;
      bg_q     <= bg_d;
    end
  end

  assign hsync   = hsync_q;
  assign vsync   = vsync_q;
  assign active  = active_q;
  assign pix_hit = hit_q;
  assign pix_id  = id_q;
  assign pix_bg  = bg_q;

`ifdef SPRITE_OVF_EN
  logic ovf_q, ovf_d;

  always_comb begin
    ovf_d = ovf_q;
    if ((h_cnt == 10'd0) && (v_cnt == 10'd0)) ovf_d = 1'b0;
    else if (drop)                            ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign spr_ovf = ovf_q;
`else
  logic ovf_unused;
  assign ovf_unused = drop;
  assign spr_ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_engine.sv
// Randomised bench for sprite_engine against a pixel-level reference model.
module tb_sprite_engine;

  localparam int SLOTS     = 4;
  localparam int SPR_W     = 16;
  localparam int MAX_PRINT = 40;
`ifdef SPRITE_OVF_EN
  localparam int OVF_ON = 1;
`else
  localparam int OVF_ON = 0;
`endif

  logic       clk    = 1'b0;
  logic       rst    = 1'b1;
  logic [4:0] spsel  = '0;
  logic [9:0] spx    = '0;
  logic [8:0] spy    = '0;
  logic       sppos  = 1'b0;
  logic       spattr = 1'b0;
  logic       spvis  = 1'b0;
  logic [1:0] bg     = '0;
  logic       hsync, vsync, active, pix_hit, spr_ovf;
  logic [4:0] pix_id;
  logic [1:0] pix_bg;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: raster position, table, slot lists as queues.
  int mh = 0, mv = 0;
  int tab_x [32];
  int tab_y [32];
  bit tab_vis [32];
  int back_x[$], back_id[$], front_x[$], front_id[$];
  bit ovf_m = 1'b0;
  bit started = 1'b0, last_edge_rst = 1'b0;
  int phase = 0;
  int out_h = -1, out_v = -1;
  bit e_hs = 1'b1, e_vs = 1'b1, e_act = 1'b0, e_hit = 1'b0, e_ovf = 1'b0;
  int e_id = 0, e_bg = 0;

  always #20 clk = ~clk;

  sprite_engine #(.SLOTS(SLOTS), .SPR_W(SPR_W)) dut (
    .clk(clk), .rst(rst), .spsel(spsel), .spx(spx), .spy(spy),
    .sppos(sppos), .spattr(spattr), .spvis(spvis), .bg(bg),
    .hsync(hsync), .vsync(vsync), .active(active), .pix_hit(pix_hit),
    .pix_id(pix_id), .pix_bg(pix_bg), .spr_ovf(spr_ovf)
  );

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= MAX_PRINT)
        $display("FAIL %s at pixel h=%0d v=%0d: got %0d, expected %0d", name, out_h, out_v, act, exp);
    end
  endtask

  task automatic pix_exp(input int h, input int v, input int hit, input int id);
    if (out_h == h && out_v == v) begin
      chk($sformatf("lit_hit_%0d_%0d", h, v), pix_hit, hit);
      chk($sformatf("lit_id_%0d_%0d", h, v), pix_id, id);
    end
  endtask

  // One model step per rising edge, using the inputs the DUT samples there.
  task automatic model_step();
    int k, t;
    started = 1'b1;
    last_edge_rst = rst;
    if (rst) begin
      mh = 0; mv = 0;
      for (int i = 0; i < 32; i++) begin
        tab_x[i] = 0; tab_y[i] = 0; tab_vis[i] = 1'b0;
      end
      back_x.delete(); back_id.delete(); front_x.delete(); front_id.delete();
      ovf_m = 1'b0;
      e_hs = 1'b1; e_vs = 1'b1; e_act = 1'b0; e_hit = 1'b0; e_id = 0; e_bg = 0;
      out_h = -1; out_v = -1;
    end else begin
      e_hs  = !(mh >= 656 && mh <= 751);
      e_vs  = !(mv >= 490 && mv <= 491);
      e_act = (mh < 640) && (mv < 480);
      e_hit = 1'b0; e_id = 0;
      if (e_act) begin
        for (int i = 0; i < front_id.size(); i++) begin
          if (!e_hit && ((mh - front_x[i] + 1024) % 1024) < SPR_W) begin
            e_hit = 1'b1; e_id = front_id[i];
          end
        end
      end
      e_bg = bg;
      out_h = mh; out_v = mv;
      if (mh == 0 && mv == 0) ovf_m = 1'b0;
      if (mh >= 641 && mh <= 672) begin
        k = mh - 641;
        t = (mv == 524) ? 0 : mv + 1;
        if (tab_vis[k] && t < 480 && ((t - tab_y[k] + 512) % 512) < SPR_W) begin
          if (back_id.size() < SLOTS) begin
            back_id.push_back(k); back_x.push_back(tab_x[k]);
          end else if (OVF_ON != 0) begin
            ovf_m = 1'b1;
          end
        end
      end
      if (mh == 799) begin
        front_x = back_x; front_id = back_id;
        back_x.delete(); back_id.delete();
      end
      if (sppos) begin tab_x[spsel] = int'(spx); tab_y[spsel] = int'(spy); end
      if (spattr) tab_vis[spsel] = spvis;
      mh++;
      if (mh == 800) begin mh = 0; mv = (mv == 524) ? 0 : mv + 1; end
    end
    e_ovf = ovf_m;
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("hsync",   hsync,   int'(e_hs));
      chk("vsync",   vsync,   int'(e_vs));
      chk("active",  active,  int'(e_act));
      chk("pix_hit", pix_hit, int'(e_hit));
      chk("pix_id",  pix_id,  e_id);
      chk("pix_bg",  pix_bg,  e_bg);
      chk("spr_ovf", spr_ovf, int'(e_ovf));
      if (last_edge_rst) begin
        chk("rst_hsync", hsync, 1);   chk("rst_vsync", vsync, 1);
        chk("rst_active", active, 0); chk("rst_hit", pix_hit, 0);
        chk("rst_id", pix_id, 0);     chk("rst_bg", pix_bg, 0);
        chk("rst_ovf", spr_ovf, 0);
      end
      if (phase == 1) begin
        pix_exp(105, 12, 1, 3);  pix_exp(99, 12, 0, 0);  pix_exp(116, 12, 0, 0);
        pix_exp(105, 10, 1, 3);  pix_exp(105, 9, 0, 0);  pix_exp(105, 26, 0, 0);
        pix_exp(207, 25, 1, 2);  pix_exp(5, 0, 0, 0);    pix_exp(5, 2, 1, 13);
        pix_exp(11, 3, 1, 13);   pix_exp(12, 2, 0, 0);   pix_exp(5, 11, 1, 13);
        pix_exp(5, 12, 0, 0);    pix_exp(55, 6, 0, 0);   pix_exp(405, 30, 1, 8);
        pix_exp(465, 35, 1, 11); pix_exp(485, 35, 0, 0);
        if (out_v == 5) begin
          if (out_h == 655) chk("lit_hs_655", hsync, 1);
          if (out_h == 656) chk("lit_hs_656", hsync, 0);
          if (out_h == 751) chk("lit_hs_751", hsync, 0);
          if (out_h == 752) chk("lit_hs_752", hsync, 1);
          if (out_h == 639) chk("lit_act_639", active, 1);
          if (out_h == 640) chk("lit_act_640", active, 0);
        end
        if (out_h == 0 && out_v == 29) chk("lit_ovf_l29", spr_ovf, 0);
        if (out_h == 0 && out_v == 31) chk("lit_ovf_l31", spr_ovf, OVF_ON);
      end
      if (phase == 3 && out_v == 0 && out_h >= 0 && out_h < 640)
        chk("post_rst_nohit", pix_hit, 0);
    end
  end

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wr(input int id, input int x, input int y, input bit pos, input bit attr, input bit vis);
    spsel = 5'(id); spx = 10'(x); spy = 9'(y); sppos = pos; spattr = attr; spvis = vis;
    $display("write id=%0d x=%0d y=%0d pos=%0d attr=%0d vis=%0d at h=%0d v=%0d", id, x, y, pos, attr, vis, mh, mv);
    cycle();
    sppos = 1'b0; spattr = 1'b0;
  endtask

  task automatic rand_cycle();
    bg = 2'($urandom_range(0, 3));
    if ($urandom_range(0, 63) == 0) begin
      spsel  = 5'($urandom_range(0, 31));
      spx    = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(1000, 1023)) : 10'($urandom_range(0, 660));
      spy    = ($urandom_range(0, 3) == 0) ? 9'($urandom_range(500, 511)) : 9'($urandom_range(0, 75));
      sppos  = 1'($urandom_range(0, 1));
      spattr = 1'($urandom_range(0, 1));
      if (!sppos && !spattr) sppos = 1'b1;
      spvis  = ($urandom_range(0, 3) != 0);
      $display("write id=%0d x=%0d y=%0d pos=%0d attr=%0d vis=%0d at h=%0d v=%0d",
               spsel, spx, spy, sppos, spattr, spvis, mh, mv);
    end
    cycle();
    sppos = 1'b0; spattr = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) cycle();
    rst = 1'b0;
    phase = 1;
    wr(3, 100, 10, 1, 1, 1);
    wr(2, 200, 10, 1, 1, 1);
    wr(7, 200, 10, 1, 1, 1);
    wr(8, 400, 30, 1, 1, 1);
    wr(9, 420, 30, 1, 1, 1);
    wr(10, 440, 30, 1, 1, 1);
    wr(11, 460, 30, 1, 1, 1);
    wr(12, 480, 30, 1, 1, 1);
    wr(13, 1020, 508, 1, 1, 1);
    wr(14, 50, 5, 1, 0, 1);
    while (mv != 47) begin
      bg = 2'($urandom_range(0, 3));
      cycle();
    end
    phase = 2;
    while (mv != 66) rand_cycle();
    while (mh != 650) rand_cycle();
    rst = 1'b1;
    $display("reset asserted at h=%0d v=%0d", mh, mv);
    cycle();
    rst = 1'b0;
    phase = 3;
    repeat (1700) rand_cycle();
    phase = 0;
    repeat (2) cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
